// File: rtl/uart_rx_oversample_if.sv
// Serial receive bundle: raw line in, received byte and status strobes out.
// The master side drives the line; the receiver takes the slave side.
interface uart_rx_oversample_if;
  logic       i_Rx;
  logic [7:0] o_Data;
  logic       o_fDone;
  logic       o_fErr;
  logic       o_fBusy;

  modport master (
    output i_Rx,
    input  o_Data,
    input  o_fDone,
    input  o_fErr,
    input  o_fBusy
  );

  modport slave (
    input  i_Rx,
    output o_Data,
    output o_fDone,
    output o_fErr,
    output o_fBusy
  );
endinterface

// File: rtl/uart_rx_oversample.sv
// 8N1 UART receiver with two-flop synchroniser and mid-bit sampling.
// Glitchy starts and bad stop bits never produce an o_fDone strobe.
module uart_rx_oversample #(
  parameter int CLKS_PER_BIT = 434
) (
  input logic            i_Clk,
  input logic            i_Rst,
  uart_rx_oversample_if.slave bus
);
  localparam int N  = CLKS_PER_BIT;
  localparam int H  = N / 2;
  localparam int CW = $clog2(N);

  localparam logic [CW-1:0] LastCnt = CW'(N - 1);
  localparam logic [CW-1:0] HalfCnt = CW'(H - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t        state, state_n;
  logic [1:0]    sync;
  logic          rx_s;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shreg, shreg_n;
  logic [7:0]    data, data_n;
  logic          done, done_n;
  logic          err, err_n;

  assign rx_s = sync[1];

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sync  <= 2'b11;
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      data  <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      sync  <= {sync[0], bus.i_Rx};
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shreg <= shreg_n;
      data  <= data_n;
      done  <= done_n;
      err   <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    data_n  = data;
    done_n  = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (cnt == HalfCnt) begin
          cnt_n = '0;
          idx_n = '0;
          // a start edge that is high again at mid-bit was noise
          state_n = rx_s ? IDLE : DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == LastCnt) begin
          shreg_n = {rx_s, shreg[7:1]};
          cnt_n   = '0;
          idx_n   = idx + 1'b1;
          if (idx == 3'd7) state_n = STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == LastCnt) begin
          cnt_n = '0;
          if (rx_s) begin
            data_n  = shreg;
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            err_n   = 1'b1;
            state_n = WAIT_HIGH;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.o_Data  = data;
  assign bus.o_fDone = done;
  assign bus.o_fErr  = err;
  assign bus.o_fBusy = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_oversample.sv
// Bench for uart_rx_oversample: serial frames vs. an arithmetic timing model.
// Strobe cycle of each frame is predicted as start + 2 + H + 9*N.
module tb_uart_rx_oversample;
  localparam int N  = 434;
  localparam int H  = N / 2;
  localparam int STOP_OFS = 2 + H + 9 * N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  int   chk = 0;
  int   pass = 0;
  int   both_cnt = 0;
  logic [7:0] model_data = 8'h00;

  int         done_cyc[$];
  logic [7:0] done_dat[$];
  int         err_cyc[$];
  logic [7:0] err_dat[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_oversample_if bus ();

  uart_rx_oversample #(
    .CLKS_PER_BIT(N)
  ) dut (
    .i_Clk(clk),
    .i_Rst(rst),
    .bus  (bus)
  );

  always @(negedge clk) begin
    if (bus.o_fDone === 1'b1) begin
      done_cyc.push_back(cyc);
      done_dat.push_back(bus.o_Data);
    end
    if (bus.o_fErr === 1'b1) begin
      err_cyc.push_back(cyc);
      err_dat.push_back(bus.o_Data);
    end
    if (bus.o_fDone === 1'b1 && bus.o_fErr === 1'b1)
      both_cnt++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    done_cyc.delete();
    done_dat.delete();
    err_cyc.delete();
    err_dat.delete();
  endtask

  // leaves the line at the stop-bit level when it returns
  task automatic send_frame(input logic [7:0] b, input int p,
                            input logic stop_lvl, output int s);
    s = cyc + 1;
    bus.i_Rx = 1'b0;
    idle(p);
    for (int k = 0; k < 8; k++) begin
      bus.i_Rx = b[k];
      idle(p);
    end
    bus.i_Rx = stop_lvl;
    idle(p);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_Rx = 1'b1;
    @(negedge clk);
    idle(3);
    chk++;
    if (bus.o_Data !== 8'h00) $display("FAIL rst_data got %h want 00", bus.o_Data);
    else pass++;
    chk++;
    if (bus.o_fDone !== 1'b0) $display("FAIL rst_done got %b want 0", bus.o_fDone);
    else pass++;
    chk++;
    if (bus.o_fErr !== 1'b0) $display("FAIL rst_err got %b want 0", bus.o_fErr);
    else pass++;
    chk++;
    if (bus.o_fBusy !== 1'b0) $display("FAIL rst_busy got %b want 0", bus.o_fBusy);
    else pass++;
    rst = 1'b0;
    idle(5);
  endtask

  task automatic test_single();
    int s[2];
    logic [7:0] b[2];
    int gc;
    logic [7:0] gd;
    b[0] = 8'hA5;
    b[1] = 8'($urandom);
    clear_log();
    send_frame(b[0], N, 1'b1, s[0]);
    idle(20);
    send_frame(b[1], N, 1'b1, s[1]);
    idle(20);
    chk++;
    if (done_cyc.size() != 2)
      $display("FAIL single_cnt got %0d want 2", done_cyc.size());
    else pass++;
    for (int i = 0; i < 2; i++) begin
      gc = (i < done_cyc.size()) ? done_cyc[i] : -1;
      gd = (i < done_dat.size()) ? done_dat[i] : 8'hxx;
      chk++;
      if (gc !== s[i] + STOP_OFS)
        $display("FAIL single_cyc%0d got %0d want %0d", i, gc, s[i] + STOP_OFS);
      else pass++;
      chk++;
      if (gd !== b[i]) $display("FAIL single_dat%0d got %h want %h", i, gd, b[i]);
      else pass++;
    end
    model_data = b[1];
    chk++;
    if (err_cyc.size() != 0) $display("FAIL single_err got %0d want 0", err_cyc.size());
    else pass++;
    chk++;
    if (bus.o_fBusy !== 1'b0) $display("FAIL single_busy got %b want 0", bus.o_fBusy);
    else pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] b[9];
    int s[9];
    int gc;
    int pc;
    logic [7:0] gd;
    b = '{8'h01, 8'h13, 8'h34, 8'h57, 8'h79, 8'h9B, 8'hBC, 8'hDF, 8'hF1};
    clear_log();
    for (int i = 0; i < 9; i++) send_frame(b[i], N, 1'b1, s[i]);
    idle(20);
    chk++;
    if (done_cyc.size() != 9) $display("FAIL burst_cnt got %0d want 9", done_cyc.size());
    else pass++;
    pc = -1;
    for (int i = 0; i < 9; i++) begin
      gc = (i < done_cyc.size()) ? done_cyc[i] : -1;
      gd = (i < done_dat.size()) ? done_dat[i] : 8'hxx;
      chk++;
      if (gd !== b[i]) $display("FAIL burst_dat%0d got %h want %h", i, gd, b[i]);
      else pass++;
      chk++;
      if (gc !== s[i] + STOP_OFS)
        $display("FAIL burst_cyc%0d got %0d want %0d", i, gc, s[i] + STOP_OFS);
      else pass++;
      if (i > 0) begin
        chk++;
        if (gc - pc !== 10 * N)
          $display("FAIL burst_gap%0d got %0d want %0d", i, gc - pc, 10 * N);
        else pass++;
      end
      pc = gc;
    end
    model_data = b[8];
    chk++;
    if (err_cyc.size() != 0) $display("FAIL burst_err got %0d want 0", err_cyc.size());
    else pass++;
  endtask

  task automatic test_glitch();
    int w;
    w = int'($urandom_range(200, 8));
    clear_log();
    bus.i_Rx = 1'b0;
    idle(5);
    chk++;
    if (bus.o_fBusy !== 1'b1) $display("FAIL glitch_busy_mid got %b want 1", bus.o_fBusy);
    else pass++;
    idle(w - 5);
    bus.i_Rx = 1'b1;
    idle(H + 10);
    chk++;
    if (bus.o_fBusy !== 1'b0) $display("FAIL glitch_busy got %b want 0", bus.o_fBusy);
    else pass++;
    chk++;
    if (done_cyc.size() + err_cyc.size() != 0)
      $display("FAIL glitch_strobe got %0d want 0", done_cyc.size() + err_cyc.size());
    else pass++;
    chk++;
    if (bus.o_Data !== model_data)
      $display("FAIL glitch_data got %h want %h", bus.o_Data, model_data);
    else pass++;
  endtask

  task automatic test_framing();
    int s1, s2;
    int gc;
    logic [7:0] gd;
    clear_log();
    send_frame(8'h3C, N, 1'b0, s1);
    idle(5 * N);
    bus.i_Rx = 1'b1;
    idle(N);
    send_frame(8'h5A, N, 1'b1, s2);
    idle(20);
    chk++;
    if (err_cyc.size() != 1) $display("FAIL ferr_cnt got %0d want 1", err_cyc.size());
    else pass++;
    gc = (err_cyc.size() > 0) ? err_cyc[0] : -1;
    gd = (err_dat.size() > 0) ? err_dat[0] : 8'hxx;
    chk++;
    if (gc !== s1 + STOP_OFS)
      $display("FAIL ferr_cyc got %0d want %0d", gc, s1 + STOP_OFS);
    else pass++;
    chk++;
    if (gd !== model_data) $display("FAIL ferr_data got %h want %h", gd, model_data);
    else pass++;
    chk++;
    if (done_cyc.size() != 1) $display("FAIL ferr_done_cnt got %0d want 1", done_cyc.size());
    else pass++;
    gc = (done_cyc.size() > 0) ? done_cyc[0] : -1;
    gd = (done_dat.size() > 0) ? done_dat[0] : 8'hxx;
    chk++;
    if (gc !== s2 + STOP_OFS)
      $display("FAIL ferr_next_cyc got %0d want %0d", gc, s2 + STOP_OFS);
    else pass++;
    chk++;
    if (gd !== 8'h5A) $display("FAIL ferr_next_dat got %h want 5a", gd);
    else pass++;
    model_data = 8'h5A;
  endtask

  task automatic test_reset_mid();
    int s2;
    int gc;
    logic [7:0] gd;
    clear_log();
    bus.i_Rx = 1'b0;
    idle(N);
    bus.i_Rx = 1'b1;
    idle(4 * N + N / 2);
    chk++;
    if (bus.o_fBusy !== 1'b1) $display("FAIL mid_busy_pre got %b want 1", bus.o_fBusy);
    else pass++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_data = 8'h00;
    chk++;
    if (bus.o_Data !== 8'h00) $display("FAIL mid_data got %h want 00", bus.o_Data);
    else pass++;
    chk++;
    if (bus.o_fBusy !== 1'b0) $display("FAIL mid_busy got %b want 0", bus.o_fBusy);
    else pass++;
    chk++;
    if ({bus.o_fDone, bus.o_fErr} !== 2'b00)
      $display("FAIL mid_strobe got %b want 00", {bus.o_fDone, bus.o_fErr});
    else pass++;
    idle(N - N / 2 - 1 + 4 * N + N);
    send_frame(8'h42, N, 1'b1, s2);
    idle(20);
    chk++;
    if (done_cyc.size() != 1 || err_cyc.size() != 0)
      $display("FAIL mid_cnt got %0d/%0d want 1/0", done_cyc.size(), err_cyc.size());
    else pass++;
    gc = (done_cyc.size() > 0) ? done_cyc[0] : -1;
    gd = (done_dat.size() > 0) ? done_dat[0] : 8'hxx;
    chk++;
    if (gd !== 8'h42) $display("FAIL mid_next_dat got %h want 42", gd);
    else pass++;
    chk++;
    if (gc !== s2 + STOP_OFS)
      $display("FAIL mid_next_cyc got %0d want %0d", gc, s2 + STOP_OFS);
    else pass++;
    model_data = 8'h42;
  endtask

  task automatic test_baud_skew();
    int p[2];
    int s[2];
    int gc;
    logic [7:0] gd;
    p[0] = 449;
    p[1] = 419;
    clear_log();
    send_frame(8'h55, p[0], 1'b1, s[0]);
    idle(2 * N);
    send_frame(8'h55, p[1], 1'b1, s[1]);
    idle(N);
    chk++;
    if (done_cyc.size() != 2 || err_cyc.size() != 0)
      $display("FAIL skew_cnt got %0d/%0d want 2/0", done_cyc.size(), err_cyc.size());
    else pass++;
    for (int i = 0; i < 2; i++) begin
      gc = (i < done_cyc.size()) ? done_cyc[i] : -1;
      gd = (i < done_dat.size()) ? done_dat[i] : 8'hxx;
      chk++;
      if (gd !== 8'h55) $display("FAIL skew_dat%0d got %h want 55", i, gd);
      else pass++;
      chk++;
      if (gc !== s[i] + STOP_OFS)
        $display("FAIL skew_cyc%0d got %0d want %0d", i, gc, s[i] + STOP_OFS);
      else pass++;
    end
    model_data = 8'h55;
    chk++;
    if (both_cnt != 0) $display("FAIL strobe_overlap got %0d want 0", both_cnt);
    else pass++;
  endtask

  initial begin
    bus.i_Rx = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_reset_mid();
    test_baud_skew();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule

// File: doc/uart_rx_oversample.md
# uart_rx_oversample

Serial byte receiver feeding the DES command/key/text front end. It synchronises the asynchronous `i_Rx` pin and detects 8N1 frames (1 start, 8 data LSB-first, 1 stop) by mid-bit sampling. Each good byte is presented on `o_Data` with a single-cycle `o_fDone` strobe. Framing errors and start-bit glitches are rejected, so the top-level byte counter only ever sees complete, valid bytes.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per bit (50 MHz / 115200). Legal range is ≥ 4.
- `i_Clk`  input  1  system clock; all logic on the rising edge.
- `i_Rst`  input  1  reset, synchronous, active-high.
- `i_Rx`  input  1  asynchronous serial line; idles high.
- `o_Data`  output  8  last good received byte.
- `o_fDone`  output  1  one-cycle strobe: `o_Data` has just been updated with a good byte.
- `o_fErr`  output  1  one-cycle strobe: stop bit sampled low (framing error).
- `o_fBusy`  output  1  high while a frame is in progress (any state other than IDLE).

## Operation
- **Synchroniser.** `i_Rx` passes through 2 flops, producing `rx_s`. The sync flops reset to 1.
- **Constants.** N = `CLKS_PER_BIT`. H = N/2, using integer division.
- **Counter.** The bit counter is $clog2(N) bits wide. The bit index is 3 bits wide.
- **IDLE.** If `rx_s`==0, go to START with counter=0. Otherwise stay.
- **START.** The counter increments each cycle.
  - At counter==H-1, sample `rx_s`.
  - If 1, the edge was a glitch: return to IDLE with no strobe.
  - If 0, go to DATA with counter=0 and index=0.
- **DATA.** The counter increments each cycle.
  - At counter==N-1, shift `rx_s` into the shift register MSB end, so the LSB arrives first.
  - Then reset counter to 0 and increment index.
  - After index 7 is sampled, go to STOP with counter=0.
- **STOP.** At counter==N-1, sample `rx_s`.
  - If 1: `o_Data` ← shift register, `o_fDone`=1, go to IDLE.
  - If 0: `o_fErr`=1, `o_Data` unchanged, go to WAIT_HIGH.
- **WAIT_HIGH.** Stay until `rx_s`==1, then go to IDLE. A break or stuck-low line therefore cannot be misread as a new start bit.
- **Reset values.** `o_Data`=0x00, `o_fDone`=0, `o_fErr`=0, `o_fBusy`=0, state=IDLE, counter=0, index=0, shift register=0.
- **Reset mid-frame.** The frame in progress is abandoned with no strobe. The remaining bits of that frame on the line are treated as fresh traffic.
- `o_fDone` and `o_fErr` are never high in the same cycle.

## Timing
- **Cycle reference.** Cycle 0 is the rising edge at which the first sync flop captures `i_Rx`=0.
  - Edge 2: IDLE sees `rx_s`=0 and enters START.
  - Start-bit sample: edge 2+H.
  - Data bit k (k=0..7) sample: edge 2+H+(k+1)·N.
  - Stop sample: edge 2+H+9·N.
- **Strobe.** `o_fDone` or `o_fErr` is registered at the stop-sample edge and is high for exactly the following cycle.
  - With N=434 this is edge 4125.
  - `o_Data` changes on the same edge as `o_fDone` rises.
- **Back-to-back frames.**
  - After a good stop sample the block is in IDLE on the next edge.
  - A start edge arriving at the nominal end of the stop bit (H cycles later) is accepted.
  - No extra idle time is required between frames.
- **Baud tolerance.** Mid-bit sampling tolerates ±4% baud mismatch, measured at the stop bit.
- **Consumer rule.** The downstream consumer must sample `o_Data` while `o_fDone`=1. `o_Data` is held until the next good byte.

## Test plan
- **Single good frame.** N=434; send 0xA5 (bits 1,0,1,0,0,1,0,1 LSB-first) → `o_fDone` high only in the cycle after edge 4125, `o_Data`=0xA5, `o_fErr` never high, `o_fBusy` low afterwards.
- **Burst.** Send 9 frames with no idle gap: command 0x01, then key bytes 0x13,0x34,0x57,0x79,0x9B,0xBC,0xDF,0xF1 → exactly 9 `o_fDone` pulses, values in order, spaced 10·N = 4340 cycles apart.
- **Glitch rejection.** Drive `i_Rx` low for 100 cycles (< H=217), then high → state returns to IDLE, no `o_fDone`/`o_fErr`, `o_Data` unchanged.
- **Framing error.** Send 0x3C with the stop bit low, then hold low for 5·N cycles, then high, then send 0x5A → one `o_fErr` pulse at the stop sample, `o_Data` stays at the prior value, no false frame while the line is low, then `o_fDone` with 0x5A.
- **Reset mid-frame.** Assert `i_Rst` for 1 cycle during data bit 4 of 0xFF → all outputs 0 on the next edge, no strobe. After the line is high for ≥ N cycles, 0x42 is received correctly.
- **Baud skew.** Transmit 0x55 at bit period 434·1.035 ≈ 449 cycles, then at 434·0.965 ≈ 419 cycles → both are received as 0x55 with `o_fDone` and no `o_fErr`.
